mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-side requester (r0) and the data-side requester (r1).
- r1 carries write-through writes and read-miss fills from the data cache controller.
- Each requester holds a level request until it receives a one-cycle ready pulse. This is the ready that the cache controllers' stall/miss FSMs wait on.
- The block performs round-robin arbitration, latches the winning request and holds the memory access for a fixed latency. It then returns read data with ready.

Parameters:
- ADDR_W, 10, word-address width (matches the 10-bit WordAddress).
- DATA_W, 32, data word width.
- LATENCY, 4, memory access cycles; legal range 1..15.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_req  in  1  instruction-side request, level, held until r0_ready.
- r0_we  in  1  r0 write enable (1=write, 0=read).
- r0_addr  in  ADDR_W  r0 word address.
- r0_wdata  in  DATA_W  r0 write data.
- r0_ready  out  1  one-cycle completion pulse for r0.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ready: same as the r0 ports, for the data side.
- rdata  out  DATA_W  read data of the last completed read; valid while rX_ready is high.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid on the last ACCESS cycle.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset values:
  - state=IDLE; cnt=0; last_grant=1, so r0 wins the first tie.
  - Latched addr/wdata/we = 0; rdata=0.
  - All outputs low/zero.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - Exactly one request: grant it.
    - Both requesting: grant the requester opposite last_grant.
    - On a grant, latch gnt, we, addr and wdata; load cnt=LATENCY-1; go to ACCESS.
  - ACCESS:
    - mem_en=1. mem_we, mem_addr and mem_wdata are driven from the latched registers and are stable for exactly LATENCY cycles.
    - If cnt!=0, decrement cnt.
    - If cnt==0: for a read, capture mem_rdata into rdata; go to RESP.
  - RESP:
    - Assert ready of the granted requester only, for one cycle. rdata holds the captured value (unchanged for writes).
    - Set last_grant=gnt; go to IDLE.
- Timing:
  - Outputs are Moore; mem_* are zero outside ACCESS.
  - Request sampled in IDLE at cycle t: mem_en high for cycles t+1..t+LATENCY; ready high at cycle t+LATENCY+1.
  - Next grant is earliest at the IDLE cycle t+LATENCY+2.
- Requests are ignored in ACCESS and RESP; no preemption. Input changes after the grant are not seen until the next IDLE.
- Requester drops req mid-transaction: the access still completes and the ready pulse is still issued.
- Requester holding req across its own ready: treated as a new request in the following IDLE and arbitrated normally. If the other side is also requesting, the other side wins.
- Fairness: with both requesting continuously, grants alternate r0,r1,r0,... and neither waits more than one transaction.
- Reset asserted in any state, including mid-ACCESS: next cycle state=IDLE, mem_en=0, ready=0, rdata=0. The aborted access produces no ready.
- cnt is 4 bits.
- LATENCY=1 gives a single ACCESS cycle.

Test Plan:
- LATENCY=4, r0 read addr 0x055 with mem_rdata=0xDEADBEEF on the last access cycle, req seen at t -> mem_en high t+1..t+4 with mem_addr=0x055; r0_ready=1 and rdata=0xDEADBEEF at t+5; r1_ready stays 0.
- r0 and r1 both request from reset, both held 4 transactions -> grant order r0,r1,r0,r1; ready pulses spaced 6 cycles apart (LATENCY+2).
- r1 write addr 0x3FF, wdata 0x12345678, while r0 read arrives mid-access -> write completes with mem_we=1 for 4 cycles; r1_ready; rdata unchanged; r0 is granted at the next IDLE.
- Reset pulsed on the 2nd ACCESS cycle of an r1 read -> next cycle mem_en=0, busy=0, no r1_ready ever; held r1_req re-granted at its first IDLE after reset (last_grant=1 rule).
- LATENCY=1, r0 read -> mem_en for exactly 1 cycle; r0_ready at t+2.
- r0 drops req one cycle after grant -> r0_ready still pulses at t+LATENCY+1; no second access.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the
// instruction-side (r0) and data-side (r1) requesters.
module mem_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ready,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                grant_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        grant_sel    = 1'b0;

        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    // On a tie the side that did not win last time goes first.
                    grant_sel = (r0_req && r1_req) ? ~last_grant_q : r1_req;
                    gnt_d     = grant_sel;
                    we_d      = grant_sel ? r1_we    : r0_we;
                    addr_d    = grant_sel ? r1_addr  : r0_addr;
                    wdata_d   = grant_sel ? r1_wdata : r0_wdata;
                    cnt_d     = CNT_INIT;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                last_grant_d = gnt_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs are forced to zero whenever no access is in flight.
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign r0_ready  = (state_q == RESP) && !gnt_q;
    assign r1_ready  = (state_q == RESP) &&  gnt_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
